// File: rtl/fifo_types_pkg.sv
// Shared types for the FIFO enqueue arbiter: the arbitration state, the
// default requester id type, and a helper that sizes requester id fields.
package fifo_types;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Id width for a given requester count; never narrower than one bit.
  function automatic int arb_id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  localparam int ARB_NUM_REQ_DEF = 4;
  localparam int ARB_ID_W        = arb_id_w(ARB_NUM_REQ_DEF);

  typedef logic [ARB_ID_W-1:0] arb_id_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: rotates the request vector so rr_ptr_i sits at bit 0,
// priority-encodes the lowest set bit, then rotates the index back.
// Purely combinational.
module rr_priority_picker #(
  parameter int num_req_p = 4,
  parameter int id_w_p    = 2
) (
  input  logic [num_req_p-1:0] req_i,
  input  logic [id_w_p-1:0]    rr_ptr_i,
  output logic [num_req_p-1:0] grant_oh_o,
  output logic [id_w_p-1:0]    grant_id_o,
  output logic                 any_o
);

  logic [num_req_p-1:0] rot;
  logic [id_w_p-1:0]    rot_idx;

  // Rotate requests so the round-robin pointer becomes the highest priority.
  always_comb begin
    rot = '0;
    for (int i = 0; i < num_req_p; i++) begin
      rot[i] = req_i[id_w_p'((i + int'(rr_ptr_i)) % num_req_p)];
    end
  end

  // Lowest set bit of the rotated vector wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    rot_idx = '0;
    any_o   = 1'b0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      if (rot[i]) begin
        rot_idx = id_w_p'(i);
        any_o   = 1'b1;
      end
    end
  end

  // Undo the rotation and form the one-hot grant.
  always_comb begin
    grant_id_o = id_w_p'((int'(rot_idx) + int'(rr_ptr_i)) % num_req_p);
    grant_oh_o = '0;
    if (any_o) begin
      grant_oh_o[grant_id_o] = 1'b1;
    end
  end

endmodule

// File: rtl/fifo_rr_enq_arbiter.sv
// Round-robin arbiter sharing one FIFO enqueue port among num_req_p producers.
// A multi-beat packet holds the grant (LOCKED) until its last beat or until
// burst_len_p beats have gone through, so packets land contiguously.
// Zero-latency combinational datapath; only arbitration state is registered.
// Optional per-requester packet counters: define FIFO_ARB_STATS_EN.
module fifo_rr_enq_arbiter
  import fifo_types::*;
#(
  parameter int num_req_p   = 4,
  parameter int width_p     = 8,
  parameter int burst_len_p = 4,
  parameter int cnt_width_p = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [num_req_p-1:0]          req_valid_i,
  input  logic [num_req_p*width_p-1:0]  req_data_i,
  input  logic [num_req_p-1:0]          req_last_i,
  output logic [num_req_p-1:0]          req_ready_o,
  output logic                          fifo_valid_o,
  output logic [width_p-1:0]            fifo_data_o,
  input  logic                          fifo_ready_i,
  output logic [arb_id_w(num_req_p)-1:0] grant_id_o,
  output logic                          locked_o
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [num_req_p*cnt_width_p-1:0] grant_cnt_o
`endif
);

  localparam int id_w_lp  = arb_id_w(num_req_p);
  localparam int cnt_w_lp = $clog2(burst_len_p + 1);

  arb_state_e           state_q, state_d;
  logic [id_w_lp-1:0]   rr_ptr_q, rr_ptr_d;
  logic [id_w_lp-1:0]   owner_q, owner_d;
  logic [id_w_lp-1:0]   last_id_q;
  logic [cnt_w_lp-1:0]  beat_cnt_q, beat_cnt_d;

  logic [num_req_p-1:0] pick_oh;
  logic [id_w_lp-1:0]   pick_id;
  logic                 pick_any;

  logic [num_req_p-1:0] sel_oh;
  logic [id_w_lp-1:0]   sel_id;
  logic                 sel_valid;
  logic                 sel_last;
  logic                 accept;
  logic                 burst_end;
  logic                 pkt_end;
  logic [id_w_lp-1:0]   next_ptr;

  rr_priority_picker #(
    .num_req_p (num_req_p),
    .id_w_p    (id_w_lp)
  ) u_picker (
    .req_i      (req_valid_i),
    .rr_ptr_i   (rr_ptr_q),
    .grant_oh_o (pick_oh),
    .grant_id_o (pick_id),
    .any_o      (pick_any)
  );

  // Selected requester: the lock owner while LOCKED, otherwise the picker's choice.
  always_comb begin
    sel_oh    = '0;
    sel_id    = pick_id;
    sel_valid = pick_any;
    if (state_q == ARB_LOCKED) begin
      sel_id          = owner_q;
      sel_oh[owner_q] = 1'b1;
      sel_valid       = req_valid_i[owner_q];
    end else begin
      sel_oh = pick_oh;
    end
  end

  // Steer the selected requester's data word to the FIFO.
  always_comb begin
    fifo_data_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (sel_id == id_w_lp'(i)) begin
        fifo_data_o = req_data_i[i*width_p +: width_p];
      end
    end
  end

  // Handshake outputs; held quiet while reset is asserted.
  always_comb begin
    fifo_valid_o = sel_valid & reset_n_i;
    req_ready_o  = sel_oh & {num_req_p{fifo_ready_i & reset_n_i}};
    locked_o     = (state_q == ARB_LOCKED);
    if (!reset_n_i) begin
      grant_id_o = '0;
    end else if (state_q == ARB_LOCKED) begin
      grant_id_o = owner_q;
    end else if (pick_any) begin
      grant_id_o = pick_id;
    end else begin
      grant_id_o = last_id_q;
    end
  end

  assign accept    = fifo_valid_o & fifo_ready_i;
  assign sel_last  = req_last_i[sel_id];
  assign burst_end = (state_q == ARB_LOCKED)
                     ? ((beat_cnt_q + cnt_w_lp'(1)) == cnt_w_lp'(burst_len_p))
                     : (burst_len_p == 1);
  assign pkt_end   = sel_last | burst_end;
  assign next_ptr  = id_w_lp'((int'(sel_id) + 1) % num_req_p);

  // Next-state: grant on IDLE accept, count beats while LOCKED, release on last/burst limit.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          if (pkt_end) begin
            rr_ptr_d = next_ptr;
          end else begin
            state_d    = ARB_LOCKED;
            owner_d    = sel_id;
            beat_cnt_d = cnt_w_lp'(1);
          end
        end
      end
      ARB_LOCKED: begin
        if (accept) begin
          if (pkt_end) begin
            state_d    = ARB_IDLE;
            rr_ptr_d   = next_ptr;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + cnt_w_lp'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Arbitration state registers; reset abandons any lock immediately.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      last_id_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      last_id_q  <= grant_id_o;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [num_req_p-1:0][cnt_width_p-1:0] grant_cnt_q;

  // Saturating count of completed packets (or packet pieces) per requester.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      // NOTE: the counter bank is a handful of flops, so it takes the async reset like any other state.
      grant_cnt_q <= '0;
    end else if (accept && pkt_end) begin
      for (int i = 0; i < num_req_p; i++) begin
        if (sel_id == id_w_lp'(i) && grant_cnt_q[i] != '1) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + cnt_width_p'(1);
        end
      end
    end
  end

  assign grant_cnt_o = grant_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rr_enq_arbiter.sv
// Self-checking bench for fifo_rr_enq_arbiter: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_fifo_rr_enq_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int BL = 4;
  localparam int CW = 16;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_valid;
  logic [W-1:0]   fifo_data;
  logic           fifo_ready;
  logic [1:0]     grant_id;
  logic           locked;
`ifdef FIFO_ARB_STATS_EN
  logic [N*CW-1:0] grant_cnt;
`endif

  fifo_rr_enq_arbiter #(
    .num_req_p   (N),
    .width_p     (W),
    .burst_len_p (BL),
    .cnt_width_p (CW)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_last_i   (req_last),
    .req_ready_o  (req_ready),
    .fifo_valid_o (fifo_valid),
    .fifo_data_o  (fifo_data),
    .fifo_ready_i (fifo_ready),
    .grant_id_o   (grant_id),
    .locked_o     (locked)
`ifdef FIFO_ARB_STATS_EN
    ,
    .grant_cnt_o  (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: who holds the port, how many beats of the current
  // burst have gone, where the round-robin search starts next.
  bit m_locked;
  int m_owner;
  int m_beats;
  int m_ptr;
  int m_last_id;
  int m_pkts [N];

  // Per-cycle prediction.
  bit         p_found;
  int         p_sel;
  bit         p_valid;
  int         p_gid;
  logic [N-1:0] p_ready;

  int t3_gid [4] = '{1, 1, 1, 2};
  int t3_lck [4] = '{0, 1, 1, 0};
  int t4_gid [7] = '{0, 0, 0, 0, 1, 0, 0};
  int t4_lck [7] = '{0, 1, 1, 1, 0, 0, 1};
  int r0_beats;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked  = 1'b0;
    m_owner   = 0;
    m_beats   = 0;
    m_ptr     = 0;
    m_last_id = 0;
    for (int i = 0; i < N; i++) m_pkts[i] = 0;
  endtask

  task automatic model_eval();
    p_found = 1'b0;
    p_sel   = 0;
    if (m_locked) begin
      p_found = 1'b1;
      p_sel   = m_owner;
      p_valid = req_valid[m_owner];
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!p_found && req_valid[(m_ptr + k) % N]) begin
          p_found = 1'b1;
          p_sel   = (m_ptr + k) % N;
        end
      end
      p_valid = p_found;
    end
    p_ready = '0;
    if (p_found && fifo_ready && reset_n) p_ready[p_sel] = 1'b1;
    if (!reset_n)     p_gid = 0;
    else if (p_found) p_gid = p_sel;
    else              p_gid = m_last_id;
    p_valid = p_valid && reset_n;
  endtask

  task automatic model_advance();
    bit accept;
    bit last;
    if (!reset_n) return;
    accept    = p_valid && fifo_ready;
    m_last_id = p_gid;
    if (accept) begin
      last = req_last[p_sel];
      if (!m_locked) begin
        if (last || BL == 1) begin
          m_ptr = (p_sel + 1) % N;
          m_pkts[p_sel]++;
        end else begin
          m_locked = 1'b1;
          m_owner  = p_sel;
          m_beats  = 1;
        end
      end else begin
        m_beats++;
        if (last || m_beats == BL) begin
          m_locked = 1'b0;
          m_ptr    = (m_owner + 1) % N;
          m_pkts[m_owner]++;
        end
      end
    end
  endtask

  task automatic eval_and_check(input string tag);
    @(negedge clk);
    model_eval();
    chk({tag, "_valid"},  32'(fifo_valid), 32'(p_valid));
    chk({tag, "_ready"},  32'(req_ready),  32'(p_ready));
    chk({tag, "_gid"},    32'(grant_id),   32'(p_gid));
    chk({tag, "_locked"}, 32'(locked),     32'(m_locked));
    if (p_valid) chk({tag, "_data"}, 32'(fifo_data), 32'(req_data[p_sel*W +: W]));
  endtask

  task automatic advance();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = '0;
    req_last   = '0;
    req_data   = '0;
    fifo_ready = 1'b1;
    model_reset();

    // 1: reset, nothing valid, FIFO ready.
    repeat (2) @(posedge clk);
    #1;
    eval_and_check("t1_rst");
    chk("t1_rst_locked", 32'(locked), 32'd0);
    chk("t1_rst_ready",  32'(req_ready), 32'd0);
    advance();
    reset_n = 1'b1;
    eval_and_check("t1");
    chk("t1_fifo_valid", 32'(fifo_valid), 32'd0);
    advance();

    // 2: four single-beat producers every cycle -> strict rotation.
    for (int k = 0; k < 8; k++) begin
      req_valid = '1;
      req_last  = '1;
      req_data  = 32'($urandom);
      eval_and_check("t2");
      chk("t2_order", 32'(grant_id), 32'(k % 4));
      advance();
    end

    // 3: req1 three-beat packet with req2 waiting.
    for (int k = 0; k < 4; k++) begin
      req_valid = '0;
      req_last  = '0;
      req_valid[1] = (k < 3);
      req_last[1]  = (k == 2);
      req_valid[2] = 1'b1;
      req_last[2]  = 1'b1;
      req_data  = {8'h30, 8'h20 + 8'(k), 8'h10 + 8'(k), 8'h00};
      eval_and_check("t3");
      chk("t3_gid",    32'(grant_id), 32'(t3_gid[k]));
      chk("t3_locked", 32'(locked),   32'(t3_lck[k]));
      advance();
    end

    // 4: req0 six-beat packet split by the four-beat burst limit.
    r0_beats = 0;
    for (int k = 0; k < 7; k++) begin
      req_valid = 4'b0011;
      req_last  = 4'b0010;
      req_last[0] = (r0_beats == 5);
      req_data  = {8'h00, 8'h00, 8'h55, 8'hA0 + 8'(r0_beats)};
      eval_and_check("t4");
      chk("t4_gid",    32'(grant_id), 32'(t4_gid[k]));
      chk("t4_locked", 32'(locked),   32'(t4_lck[k]));
      if (req_ready[0]) r0_beats++;
      advance();
    end
    chk("t4_r0_beats", 32'(r0_beats), 32'd6);

    // 5: FIFO full for five cycles mid-burst.
    for (int k = 0; k < 10; k++) begin
      req_valid  = 4'b1100;
      req_last   = 4'b1000;
      req_data   = 32'($urandom);
      fifo_ready = !(k >= 2 && k <= 6);
      eval_and_check("t5");
      chk("t5_gid",    32'(grant_id), (k < 9) ? 32'd2 : 32'd3);
      chk("t5_locked", 32'(locked),   (k >= 1 && k <= 8) ? 32'd1 : 32'd0);
      if (!fifo_ready) chk("t5_stall_ready", 32'(req_ready), 32'd0);
      advance();
    end
    fifo_ready = 1'b1;

    // 6: reset pulsed while LOCKED.
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    eval_and_check("t6_a");
    chk("t6_a_gid", 32'(grant_id), 32'd1);
    advance();
    req_valid = 4'b1000;
    req_last  = 4'b0000;
    eval_and_check("t6_b");
    chk("t6_b_gid", 32'(grant_id), 32'd3);
    advance();
    chk("t6_locked_before", 32'(locked), 32'd1);
    req_valid = 4'b1010;
    req_last  = 4'b1111;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("t6_async_locked", 32'(locked),     32'd0);
    chk("t6_async_valid",  32'(fifo_valid), 32'd0);
    chk("t6_async_gid",    32'(grant_id),   32'd0);
    eval_and_check("t6_in_rst");
    advance();
    reset_n = 1'b1;
    eval_and_check("t6_post");
    chk("t6_post_gid", 32'(grant_id), 32'd1);
    advance();

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      req_valid = 4'($urandom);
      for (int i = 0; i < N; i++) req_last[i] = ($urandom_range(0, 9) < 4);
      req_data   = 32'($urandom);
      fifo_ready = ($urandom_range(0, 3) != 0);
      eval_and_check("rnd");
      advance();
    end

`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      chk("stat_cnt", 32'(grant_cnt[i*CW +: CW]), 32'(m_pkts[i]));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
